// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader for the pipe_MIPS32 instruction/data memory.
// Assembles big-endian words, writes them to Mem, then releases the CPU at the frame start PC.
module mips32_prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_value,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte transfers on a rising edge where in_valid & in_ready and start is low;
    // in_ready is registered, so it is stable for the whole cycle and never depends on in_valid.
    localparam logic [2:0] S_HDR  = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_CSUM = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       shift_q, shift_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              pc_load_q, pc_load_d;
    logic [ADDR_W-1:0] pc_value_q, pc_value_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic [15:0]       word_idx_inc;

    assign accept       = in_valid & in_ready_q & ~start;
    assign word_idx_inc = word_idx_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        pc_load_d   = 1'b0;
        pc_value_d  = pc_value_q;
        done_d      = done_q;
        err_d       = err_q;

        if (accept) begin
            csum_d = csum_q ^ in_data;
            case (state_q)
                S_HDR: begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: addr_d[15:8] = in_data;
                        2'd1: addr_d[7:0]  = in_data;
                        2'd2: cnt_d[15:8]  = in_data;
                        default: begin
                            cnt_d[7:0] = in_data;
                            state_d    = ({cnt_q[15:8], in_data} == 16'd0) ? S_CSUM : S_DATA;
                        end
                    endcase
                end
                S_DATA: begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], in_data};
                    if (byte_cnt_q == 2'd3) begin
                        // Word address wraps naturally at the Mem depth.
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q[ADDR_W-1:0] + word_idx_q[ADDR_W-1:0];
                        mem_wdata_d = {shift_q, in_data};
                        word_idx_d  = word_idx_inc;
                        if (word_idx_inc == cnt_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (in_data == csum_q) begin
                        state_d    = S_DONE;
                        pc_load_d  = 1'b1;
                        pc_value_d = addr_q[ADDR_W-1:0];
                        done_d     = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // The CPU is released one cycle after the PC has been loaded.
        if (pc_load_q) begin
            cpu_hold_d = 1'b0;
        end

        if (start) begin
            state_d    = S_HDR;
            byte_cnt_d = 2'd0;
            addr_d     = 16'd0;
            cnt_d      = 16'd0;
            word_idx_d = 16'd0;
            csum_d     = 8'd0;
            shift_d    = 24'd0;
            mem_we_d   = 1'b0;
            pc_load_d  = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            cpu_hold_d = 1'b1;
        end

        in_ready_d = ~start & ((state_d == S_HDR) | (state_d == S_DATA) | (state_d == S_CSUM));
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR;
            in_ready_q  <= 1'b0;
            byte_cnt_q  <= 2'd0;
            addr_q      <= 16'd0;
            cnt_q       <= 16'd0;
            word_idx_q  <= 16'd0;
            csum_q      <= 8'd0;
            shift_q     <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            pc_load_q   <= 1'b0;
            pc_value_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            shift_q     <= shift_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            pc_load_q   <= pc_load_d;
            pc_value_q  <= pc_value_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign pc_load   = pc_load_q;
    assign pc_value  = pc_value_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: frames are built from word lists, expected Mem writes
// and PC loads are queued up front and matched by a monitor as the DUT produces them.
module tb_mips32_prog_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_value;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    always #5 clk1 = ~clk1;

    mips32_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .pc_load(pc_load),
        .pc_value(pc_value), .done(done), .err(err), .dbg_state(dbg_state)
    );

    int tests = 0;
    int fails = 0;
    int pc_seen = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_pc_q[$];
    logic [31:0]        words_q[$];
    logic [7:0]         bytes_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes Mem or loads the PC.
    always @(negedge clk1) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_addr, mem_wdata}, 64'hDEAD);
            end else begin
                check("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
        if (rst_n === 1'b1 && pc_load === 1'b1) begin
            pc_seen++;
            check("hold_at_pc_load", cpu_hold, 1);
            check("done_at_pc_load", done, 1);
            if (exp_pc_q.size() == 0) begin
                check("unexpected_pc_load", pc_value, 64'hDEAD);
            end else begin
                check("pc_value", pc_value, exp_pc_q.pop_front());
            end
        end
    end

    task automatic build_frame(input logic [15:0] a, input bit bad);
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        n = 16'(words_q.size());
        bytes_q.delete();
        bytes_q.push_back(a[15:8]);
        bytes_q.push_back(a[7:0]);
        bytes_q.push_back(n[15:8]);
        bytes_q.push_back(n[7:0]);
        for (int i = 0; i < words_q.size(); i++) begin
            w = words_q[i];
            for (int b = 3; b >= 0; b--) bytes_q.push_back(w[b*8 +: 8]);
        end
        cs = 8'd0;
        foreach (bytes_q[i]) cs = cs ^ bytes_q[i];
        bytes_q.push_back(bad ? (cs ^ 8'h01) : cs);
    endtask

    // Expected writes for the first nwords words of the current frame.
    task automatic push_writes(input logic [15:0] a, input int nwords);
        int base;
        logic [ADDR_W-1:0] wa;
        base = int'(a) % DEPTH;
        for (int i = 0; i < nwords; i++) begin
            wa = ADDR_W'((base + i) % DEPTH);
            exp_q.push_back({wa, words_q[i]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit sent;
        int budget;
        sent = 0;
        budget = 0;
        while (!sent) begin
            @(negedge clk1);
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                sent     = (in_ready === 1'b1);
            end
            budget++;
            if (!sent && budget > 200) begin
                check("send_timeout", 0, 1);
                sent = 1;
            end
        end
    endtask

    task automatic pulse_start(input bit with_valid);
        @(negedge clk1);
        start    = 1'b1;
        in_valid = with_valid;
        in_data  = 8'hA5;
        @(negedge clk1);
        start    = 1'b0;
        in_valid = 1'b0;
        check("ready_after_start", in_ready, 0);
        check("done_after_start", done, 0);
        check("err_after_start", err, 0);
        check("hold_after_start", cpu_hold, 1);
    endtask

    // Sends the whole frame in bytes_q, then pokes in_valid while idle and checks the end state.
    task automatic run_frame(input logic [15:0] a, input bit bad, input int gap_pct);
        int pc_before;
        build_frame(a, bad);
        push_writes(a, words_q.size());
        if (!bad) exp_pc_q.push_back(ADDR_W'(int'(a) % DEPTH));
        pc_before = pc_seen;
        foreach (bytes_q[i]) send_byte(bytes_q[i], gap_pct);
        @(negedge clk1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk1);
        in_valid = 1'b0;
        check("frame_done", done, !bad);
        check("frame_err", err, bad);
        check("frame_hold", cpu_hold, bad);
        check("frame_ready", in_ready, 0);
        check("pc_load_count", pc_seen - pc_before, bad ? 0 : 1);
        check("writes_drained", exp_q.size(), 0);
        check("pc_drained", exp_pc_q.size(), 0);
    endtask

    task automatic send_partial(input logic [15:0] a, input int ndata);
        build_frame(a, 0);
        push_writes(a, ndata / 4);
        for (int i = 0; i < 4 + ndata; i++) send_byte(bytes_q[i], 0);
    endtask

    task automatic check_reset_values();
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_value", pc_value, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    task automatic load_frame1();
        words_q = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                    32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk1);
        check_reset_values();
        rst_n = 1'b1;
        #1 check("ready_at_release", in_ready, 0);
        @(negedge clk1);
        check("ready_after_release", in_ready, 1);

        load_frame1();
        run_frame(16'h0000, 0, 0);

        pulse_start(1);
        run_frame(16'h0000, 1, 0);

        pulse_start(0);
        words_q = '{32'h11111111, 32'h22222222};
        run_frame(16'h03FF, 0, 0);

        pulse_start(0);
        words_q.delete();
        run_frame(16'h1234, 0, 0);

        pulse_start(0);
        load_frame1();
        run_frame(16'h0000, 0, 30);

        // Abort mid-frame with start (byte offered in the same cycle must be dropped).
        pulse_start(0);
        send_partial(16'h0000, 6);
        pulse_start(1);
        run_frame(16'h0000, 0, 0);

        // Asynchronous reset mid-word.
        pulse_start(0);
        send_partial(16'h0000, 6);
        @(negedge clk1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk1);
        rst_n = 1'b1;
        run_frame(16'h0000, 0, 0);

        for (int f = 0; f < 6; f++) begin
            logic [15:0] ra;
            int nw;
            bit rbad;
            pulse_start($urandom_range(1));
            ra   = 16'($urandom_range(16'hFFFF));
            nw   = $urandom_range(6);
            rbad = ($urandom_range(3) == 0);
            words_q.delete();
            for (int i = 0; i < nw; i++) words_q.push_back($urandom);
            run_frame(ra, rbad, $urandom_range(40));
        end

        repeat (4) @(negedge clk1);
        check("final_writes_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
